// File: rtl/lyr2_sched.sv
// lyr2_sched: time-multiplexes one external two-input MAC across the N_OUT
// neurons of a two-input dense layer, then streams the results out.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data    weight/bias write port, address 3k+{0,1,2} =
//                               w1[k], w2[k], b[k]; honoured only while idle
//   start, d1, d2               launch one evaluation and latch the input vector
//   mac_d1/d2/w1/w2/b, mac_res  operands to and result from the external MAC
//   out_valid/out_ready         result stream handshake
//   out_data, out_idx           neuron result and its index
//   busy, done                  not-idle flag, end-of-evaluation pulse
module lyr2_sched #(
  parameter int N_OUT = 4,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [15:0]   cfg_data,
  input  logic          start,
  input  logic [15:0]   d1,
  input  logic [15:0]   d2,
  output logic [15:0]   mac_d1,
  output logic [15:0]   mac_d2,
  output logic [15:0]   mac_w1,
  output logic [15:0]   mac_w2,
  output logic [15:0]   mac_b,
  input  logic [15:0]   mac_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic [3:0]    out_idx,
  output logic          busy,
  output logic          done
);

  localparam int         KW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [3:0] K_LAST = 4'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [KW-1:0]   kidx;
  logic [KW-1:0]   wsel;

  logic [15:0]     d1_q, d2_q;
  logic [15:0]     w1_q  [0:N_OUT-1];
  logic [15:0]     w2_q  [0:N_OUT-1];
  logic [15:0]     b_q   [0:N_OUT-1];
  logic [15:0]     res_q [0:N_OUT-1];

  logic            cfg_ok;

  assign kidx   = k_q[KW-1:0];
  // Outside RUN the MAC sees entry 0 so its operands stay quiet and defined.
  assign wsel   = (state_q == S_RUN) ? kidx : '0;
  assign cfg_ok = cfg_we && (state_q == S_IDLE);

  // Next-state and neuron counter
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          state_d = S_OUT;
          k_d     = '0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (k_q == K_LAST) begin
            state_d = S_DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Input vector, configuration table and result buffer. Reset clears all of
  // them so the MAC operands are zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q <= '0;
      d2_q <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        w1_q[j]  <= '0;
        w2_q[j]  <= '0;
        b_q[j]   <= '0;
        res_q[j] <= '0;
      end
    end else begin
      if ((state_q == S_IDLE) && start) begin
        d1_q <= d1;
        d2_q <= d2;
      end
      // Addresses beyond the last neuron match no slot and are dropped.
      if (cfg_ok) begin
        for (int j = 0; j < N_OUT; j++) begin
          if (cfg_addr == AW'(3 * j))     w1_q[j] <= cfg_data;
          if (cfg_addr == AW'(3 * j + 1)) w2_q[j] <= cfg_data;
          if (cfg_addr == AW'(3 * j + 2)) b_q[j]  <= cfg_data;
        end
      end
      if (state_q == S_RUN) begin
        res_q[kidx] <= mac_res;
      end
    end
  end

  assign mac_d1    = d1_q;
  assign mac_d2    = d2_q;
  assign mac_w1    = w1_q[wsel];
  assign mac_w2    = w2_q[wsel];
  assign mac_b     = b_q[wsel];

  // Stream outputs are zero unless a result is being offered.
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_valid ? res_q[kidx] : '0;
  assign out_idx   = out_valid ? k_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: doc/lyr2_sched.md
# lyr2_sched

Sequencer that time-multiplexes one two-input MAC (two 16-bit fixed-point multipliers plus bias add) across the `N_OUT` neurons of a two-input dense layer. It holds per-neuron weights and biases loaded through a config write port, and latches a 2-element input vector on `start`. It drives the MAC once per neuron per cycle and buffers the results, then streams them out over a valid/ready interface. It sits between the previous layer's output vector and the next layer's input stage of the VAE forward path.

## Interface
Parameters:
- `N_OUT`, 4: neurons in the layer, 2..16.
- `AW`, 6: config address width; must satisfy 2^AW >= 3*N_OUT.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_we`  in  1: config write strobe.
- `cfg_addr`  in  AW: address. 3k+0 = w1[k], 3k+1 = w2[k], 3k+2 = b[k].
- `cfg_data`  in  16: write data.
- `start`  in  1: begin one layer evaluation.
- `d1`, `d2`  in  16 each: input vector, sampled on the accepted `start` edge.
- `mac_d1`, `mac_d2`, `mac_w1`, `mac_w2`, `mac_b`  out  16 each: operands to the external MAC.
- `mac_res`  in  16: combinational MAC result.
- `out_valid`  out  1: `out_data` valid.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  16: neuron result.
- `out_idx`  out  4: neuron index of `out_data`.
- `busy`  out  1: high whenever state != IDLE.
- `done`  out  1: one-cycle pulse at end of evaluation.

## Operation
- States:
  - IDLE: `start` latches `d1`/`d2` into input registers, clears `k`, goes to RUN.
  - RUN: drives the MAC with neuron `k`; captures `mac_res` into `res[k]` at the edge; increments `k`. After `k = N_OUT-1`, goes to OUT with `k` cleared.
  - OUT: presents `res[k]` on `out_data`/`out_idx` with `out_valid=1`. Advances on `out_valid & out_ready`. After the last transfer, goes to DONE.
  - DONE: `done=1` for one cycle, then IDLE.
- MAC operands:
  - `mac_d1`/`mac_d2` = latched inputs in every state.
  - `mac_w1`/`mac_w2`/`mac_b` = entry `k` in RUN, entry 0 otherwise.
- Arithmetic: the block does no arithmetic on data. `res[k]` is `mac_res` bit-exact, and wrap/format are owned by the MAC.
- Config:
  - Writes are applied only in IDLE.
  - `cfg_we` in any other state is dropped.
  - Addresses >= 3*N_OUT are dropped.
- Simultaneous `cfg_we` and `start` in IDLE: both take effect at the same edge, and RUN uses the newly written value.
- `start` outside IDLE is ignored; there is no queueing.
- Reset values:
  - State IDLE, `k=0`.
  - All weights, biases, input and result registers 0.
  - `out_valid=0`, `out_data=0`, `out_idx=0`, `busy=0`, `done=0`.
  - Therefore all `mac_*` outputs are 0 out of reset.
- Reset mid-RUN or mid-OUT: returns to IDLE next cycle and clears the config. No `done` pulse, and `out_valid` drops immediately at that edge.

## Timing
- Edge 0 accepts `start`.
- Cycles 1..N_OUT: RUN, one neuron per cycle.
- Cycle N_OUT+1: first `out_valid`.
- With `out_ready` held high, one result per cycle (cycles N_OUT+1..2*N_OUT). `done` rises in cycle 2*N_OUT+1 and IDLE resumes at cycle 2*N_OUT+2.
- Minimum start-to-start spacing is 2*N_OUT+2 cycles.
- `out_data`/`out_idx` are stable while `out_valid & !out_ready`; backpressure of any length is allowed.
- `done` and `out_valid` are never high in the same cycle.
- `busy` is high from cycle 1 through the `done` cycle inclusive.

## Test plan
- Reset, then idle 5 cycles → every output 0, `busy=0`.
- Program N_OUT=4 with w1[k]=0x0100+k, w2[k]=0x0200+k, b[k]=0x0300+k. Start with d1=0x0011, d2=0x0022 → in RUN cycle k, `mac_w1=0x0100+k`, `mac_w2=0x0200+k`, `mac_b=0x0300+k`, `mac_d1=0x0011`, `mac_d2=0x0022`. Bench model `mac_res = mac_b ^ 0xA000` → out stream is idx 0..3 with data 0xA300..0xA303.
- Hold `out_ready=0` for 7 cycles at idx 1 → `out_data`/`out_idx` stay 0xA301/1. `done` pulses exactly once after idx 3 is accepted.
- Write cfg addr 0 with 0xFFFF while busy → ignored, so next run shows `mac_w1=0x0100` for k=0. Pulse `start` during RUN → no restart, and the stream count stays 4.
- Same-cycle `cfg_we` (addr 2, 0x7777) and `start` in IDLE → RUN cycle 0 shows `mac_b=0x7777`. Address 12 write → no register changes.
- Assert `rst` in OUT at idx 2 → next cycle IDLE, `out_valid=0`, no `done`. A new run after reprogramming produces a complete 4-result stream.
